// File: rtl/lzrw1_item_parser.sv
// LZRW1 item parser: splits a compressed byte stream into control groups and
// presents literal/copy items as 16-bit words with their control bit.
module lzrw1_item_parser #(
  parameter int unsigned GROUP_ITEMS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_in_valid,
  input  logic        byte_in_last,
  output logic        byte_in_ready,
  output logic [15:0] data_out,
  output logic        control_bit_out,
  output logic        data_out_valid,
  input  logic        decompressor_busy,
  output logic        stream_done,
  output logic        format_error
);

  localparam int unsigned KW     = 4;
  localparam logic [KW-1:0] K_LAST = KW'(GROUP_ITEMS - 1);
  localparam bit          ONE_CW = (GROUP_ITEMS == 8);

  typedef enum logic [2:0] {
    CW_LO,
    CW_HI,
    ITEM_B0,
    ITEM_B1,
    PRESENT
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   cw_q, cw_d;
  logic [KW-1:0] k_q, k_d;
  logic [7:0]    b0_q, b0_d;
  logic          last_q, last_d;
  logic [15:0]   data_d;
  logic          ctl_d, valid_d, ready_d, done_d, err_d;
  logic          take, xfer;

  assign take = byte_in_valid & byte_in_ready;
  assign xfer = data_out_valid & ~decompressor_busy;

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cw_d    = cw_q;
    k_d     = k_q;
    b0_d    = b0_q;
    last_d  = last_q;
    data_d  = data_out;
    ctl_d   = control_bit_out;
    done_d  = 1'b0;
    err_d   = format_error;
    case (state_q)
      CW_LO: begin
        if (take) begin
          cw_d[7:0] = byte_in;
          if (ONE_CW) begin
            cw_d[15:8] = 8'h00;
            done_d     = byte_in_last;
            state_d    = byte_in_last ? CW_LO : ITEM_B0;
          end else if (byte_in_last) begin
            err_d   = 1'b1;
            state_d = CW_LO;
          end else begin
            state_d = CW_HI;
          end
        end
      end
      CW_HI: begin
        if (take) begin
          cw_d[15:8] = byte_in;
          done_d     = byte_in_last;
          state_d    = byte_in_last ? CW_LO : ITEM_B0;
        end
      end
      ITEM_B0: begin
        if (take) begin
          b0_d = byte_in;
          if (cw_q[k_q]) begin
            // A copy item cut after its first byte is dropped entirely
            if (byte_in_last) begin
              err_d   = 1'b1;
              k_d     = '0;
              state_d = CW_LO;
            end else begin
              state_d = ITEM_B1;
            end
          end else begin
            data_d  = {8'h00, byte_in};
            ctl_d   = 1'b0;
            last_d  = byte_in_last;
            state_d = PRESENT;
          end
        end
      end
      ITEM_B1: begin
        if (take) begin
          data_d  = {b0_q, byte_in};
          ctl_d   = 1'b1;
          last_d  = byte_in_last;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (xfer) begin
          if (last_q) begin
            done_d  = 1'b1;
            k_d     = '0;
            state_d = CW_LO;
          end else if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = CW_LO;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = ITEM_B0;
          end
        end
      end
      default: state_d = CW_LO;
    endcase
    valid_d = (state_d == PRESENT);
    ready_d = (state_d != PRESENT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= CW_LO;
      cw_q            <= '0;
      k_q             <= '0;
      b0_q            <= '0;
      last_q          <= 1'b0;
      data_out        <= '0;
      control_bit_out <= 1'b0;
      data_out_valid  <= 1'b0;
      byte_in_ready   <= 1'b0;
      stream_done     <= 1'b0;
      format_error    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cw_q            <= cw_d;
      k_q             <= k_d;
      b0_q            <= b0_d;
      last_q          <= last_d;
      data_out        <= data_d;
      control_bit_out <= ctl_d;
      data_out_valid  <= valid_d;
      byte_in_ready   <= ready_d;
      stream_done     <= done_d;
      format_error    <= err_d;
    end
  end

endmodule

// File: tb/tb_lzrw1_item_parser.sv
// Scoreboard bench for lzrw1_item_parser: a stream-level reference model
// predicts items, stream_done pulses and format_error for each byte stream.
module tb_lzrw1_item_parser;

  localparam int G  = 16;
  localparam int CB = G / 8;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_in_valid = 1'b0;
  logic        byte_in_last = 1'b0;
  logic        byte_in_ready;
  logic [15:0] data_out;
  logic        control_bit_out;
  logic        data_out_valid;
  logic        decompressor_busy = 1'b0;
  logic        stream_done;
  logic        format_error;

  lzrw1_item_parser #(.GROUP_ITEMS(G)) dut (
    .clock             (clock),
    .reset             (rst_n),
    .byte_in           (byte_in),
    .byte_in_valid     (byte_in_valid),
    .byte_in_last      (byte_in_last),
    .byte_in_ready     (byte_in_ready),
    .data_out          (data_out),
    .control_bit_out   (control_bit_out),
    .data_out_valid    (data_out_valid),
    .decompressor_busy (decompressor_busy),
    .stream_done       (stream_done),
    .format_error      (format_error)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int exp_done    = 0;
  int done_seen   = 0;
  bit exp_err     = 1'b0;
  bit rand_busy   = 1'b0;
  logic [16:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: walks a whole stream group by group
  task automatic model_stream(input logic [7:0] b[$], input bit l[$]);
    int i = 0;
    int n = b.size();
    while (i < n) begin
      bit ended = 1'b0;
      logic [15:0] cw = '0;
      for (int j = 0; j < CB && !ended && i < n; j++) begin
        cw[8*j +: 8] = b[i];
        if (l[i]) begin
          if (j == CB - 1) exp_done++;
          else exp_err = 1'b1;
          ended = 1'b1;
        end
        i++;
      end
      for (int kk = 0; kk < G && !ended && i < n; kk++) begin
        if (cw[kk]) begin
          if (l[i]) begin
            exp_err = 1'b1;
            ended = 1'b1;
            i++;
          end else if (i + 1 >= n) begin
            ended = 1'b1;
            i = n;
          end else begin
            exp_q.push_back({1'b1, b[i], b[i+1]});
            if (l[i+1]) begin exp_done++; ended = 1'b1; end
            i += 2;
          end
        end else begin
          exp_q.push_back({1'b0, 8'h00, b[i]});
          if (l[i]) begin exp_done++; ended = 1'b1; end
          i++;
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken
  task automatic send_byte(input logic [7:0] b, input bit last, input bit gaps);
    int n = 0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) @(negedge clock);
    end
    byte_in = b;
    byte_in_last = last;
    byte_in_valid = 1'b1;
    while (!byte_in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'd1, 32'd0);
    @(negedge clock);
    byte_in_valid = 1'b0;
    byte_in_last = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] b[$], input bit l[$], input bit gaps);
    model_stream(b, l);
    for (int i = 0; i < b.size(); i++) send_byte(b[i], l[i], gaps);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || data_out_valid) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 1000) chk({nm, "_drain_timeout"}, 32'd1, 32'd0);
    repeat (2) @(negedge clock);
    chk({nm, "_done_count"}, 32'(done_seen), 32'(exp_done));
    chk({nm, "_format_error"}, 32'(format_error), 32'(exp_err));
  endtask

  always @(negedge clock) begin
    if (rand_busy) decompressor_busy = ($urandom_range(0, 2) == 0);
  end

  // Monitor: pops an expectation for each transfer about to happen
  logic        prev_hold = 1'b0;
  logic [16:0] prev_item = '0;
  always begin
    @(negedge clock);
    #2;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) chk("hold_stable", {14'd0, data_out_valid, control_bit_out, data_out},
                         {14'd0, 1'b1, prev_item});
      if (stream_done) done_seen++;
      if (data_out_valid && !decompressor_busy) begin
        if (exp_q.size() == 0) chk("unexpected_transfer", {15'd0, control_bit_out, data_out}, 32'h1_ffff);
        else chk("item", {15'd0, control_bit_out, data_out}, {15'd0, exp_q.pop_front()});
      end
      prev_hold = data_out_valid && decompressor_busy;
      prev_item = {control_bit_out, data_out};
    end
  end

  initial begin
    logic [7:0] b[$];
    bit l[$];

    // Reset state
    repeat (3) @(negedge clock);
    chk("reset_outputs", {11'd0, data_out, control_bit_out, data_out_valid, byte_in_ready,
        stream_done, format_error}, 32'd0);
    rst_n = 1'b1;
    @(negedge clock);
    chk("ready_after_release", 32'(byte_in_ready), 32'd1);

    // Literal group
    b = {8'h00, 8'h00};
    for (int i = 0; i < 16; i++) b.push_back(8'(8'h41 + i));
    l = {};
    foreach (b[i]) l.push_back(1'b0);
    send_stream(b, l, 1'b0);
    drain("literal_group");
    chk("literal_back_to_cw", 32'(byte_in_ready), 32'd1);

    // Mixed with end of stream
    b = {8'h01, 8'h00, 8'h12, 8'h34, 8'h78};
    l = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    send_stream(b, l, 1'b0);
    drain("mixed");

    // Backpressure on a presented literal
    decompressor_busy = 1'b1;
    b = {8'h00, 8'h00, 8'h5A};
    l = {1'b0, 1'b0, 1'b1};
    send_stream(b, l, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", {15'd0, data_out_valid, data_out}, {15'd0, 1'b1, 16'h005A});
      chk("bp_ready", 32'(byte_in_ready), 32'd0);
      @(negedge clock);
    end
    decompressor_busy = 1'b0;
    @(negedge clock);
    chk("bp_single_transfer", 32'(data_out_valid), 32'd0);
    drain("backpressure");

    // Group wrap: item 15 is a copy, then a new all-copy group
    b = {8'h00, 8'h80};
    for (int i = 0; i < 15; i++) b.push_back(8'(8'h60 + i));
    b.push_back(8'hC1); b.push_back(8'hC2);
    b.push_back(8'hFF); b.push_back(8'hFF);
    b.push_back(8'hAB); b.push_back(8'hCD);
    l = {};
    foreach (b[i]) l.push_back(i == b.size() - 1);
    send_stream(b, l, 1'b0);
    drain("group_wrap");

    // Truncated copy item
    b = {8'h01, 8'h00, 8'hAB};
    l = {1'b0, 1'b0, 1'b1};
    send_stream(b, l, 1'b0);
    chk("trunc_error", 32'(format_error), 32'd1);
    chk("trunc_ready", 32'(byte_in_ready), 32'd1);
    b = {8'h00, 8'h00, 8'h11, 8'h22};
    l = {1'b0, 1'b0, 1'b0, 1'b1};
    send_stream(b, l, 1'b0);
    drain("after_trunc");

    // Mid-item reset
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {11'd0, data_out, control_bit_out, data_out_valid, byte_in_ready,
        stream_done, format_error}, 32'd0);
    exp_err = 1'b0;
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    b = {8'h00, 8'h00, 8'h41};
    l = {1'b0, 1'b0, 1'b1};
    send_stream(b, l, 1'b0);
    drain("after_reset");

    // Randomized streams with random gaps and backpressure
    rand_busy = 1'b1;
    for (int s = 0; s < 40; s++) begin
      int len = $urandom_range(1, 40);
      b = {};
      l = {};
      for (int i = 0; i < len; i++) begin
        b.push_back(8'($urandom));
        l.push_back(i == len - 1);
      end
      send_stream(b, l, 1'b1);
      drain("random");
    end
    rand_busy = 1'b0;
    decompressor_busy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
